instruction_fetch: RTL

Fetch stage of the single-cycle-issue CPU. It owns the program counter, drives word addresses into the synchronous instruction memory, and collects the returned words. Each returned word is paired with its PC and delivered to decode through a valid/ready interface. A 2-entry buffer absorbs the memory's 1-cycle read latency under backpressure, and branch/jump redirects flush all in-flight work.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/instruction_fetch.sv | 77 +++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: address/data widths, reset PC and the fetch packet
// that carries an instruction word together with its word address.
package cpu_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] RESET_PC = '0;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fetch_pkt_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of fetch packets between the instruction memory response and
// decode. Flush empties it in one cycle and takes priority over push/pop.
module fetch_fifo
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fetch_pkt_t din,
    output logic [1:0] count,
    output fetch_pkt_t head
);

    fetch_pkt_t entries [2];
    logic       rd_ptr;
    logic       wr_ptr;

    // Storage is cleared on reset so the head reads as zero before anything
    // has been fetched; a flush only rewinds the pointers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            entries[0] <= '0;
            entries[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (flush) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                entries[wr_ptr] <= din;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = entries[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues word addresses to the synchronous
// instruction memory and hands {instr, pc} pairs to decode via valid/ready.
module instruction_fetch
    import cpu_pkg::fetch_pkt_t;
#(
    parameter int                ADDR_W   = cpu_pkg::ADDR_W,
    parameter int                DATA_W   = cpu_pkg::DATA_W,
    parameter logic [ADDR_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic [1:0]        count;
    logic [2:0]        occupancy;
    logic              pop;
    logic              push;
    logic              issue;
    fetch_pkt_t        push_pkt;
    fetch_pkt_t        head;

    assign pop       = out_valid & out_ready;
    assign push      = inflight & ~redirect_valid;
    assign out_valid = (count != 2'd0);

    // Slots claimed after this edge: only issue when the outstanding read is
    // guaranteed a FIFO entry, so the buffer can never overflow.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign issue     = ~redirect_valid & (occupancy < 3'd2);

    assign imem_addr = fetch_pc;
    assign push_pkt  = '{instr: imem_data, pc: inflight_pc};

    // A redirect discards the outstanding response and restarts at the target.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            inflight    <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 1'b1;
            end
        end
    end

    fetch_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .din   (push_pkt),
        .count (count),
        .head  (head)
    );

    assign out_instr = head.instr;
    assign out_pc    = head.pc;

endmodule
